// File: rtl/turn_scheduler_if.sv
// rtl/turn_scheduler_if.sv - keyboard, player and status signals of the turn scheduler
interface turn_scheduler_if;
    logic [7:0]  keycode;
    logic        exploded0;
    logic        exploded1;
    logic        alive0;
    logic        alive1;
    logic [7:0]  key0;
    logic [7:0]  key1;
    logic        active_player;
    logic [2:0]  state;
    logic [11:0] time_left;
    logic [1:0]  winner;
    logic        game_over;

    modport master (
        output keycode, exploded0, exploded1, alive0, alive1,
        input  key0, key1, active_player, state, time_left, winner, game_over
    );

    modport slave (
        input  keycode, exploded0, exploded1, alive0, alive1,
        output key0, key1, active_player, state, time_left, winner, game_over
    );
endinterface

// File: rtl/turn_scheduler.sv
// rtl/turn_scheduler.sv - two-player turn sequencer with keycode routing and game result
module turn_scheduler #(
    parameter int TURN_FRAMES    = 1800,
    parameter int LAUNCH_HOLD    = 20,
    parameter int FLIGHT_TIMEOUT = 600,
    parameter int SETTLE_FRAMES  = 60
) (
    input  logic             frame_clk,
    input  logic             reset,
    turn_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_AIM      = 3'd1,
        S_LAUNCH   = 3'd2,
        S_FLIGHT   = 3'd3,
        S_SETTLE   = 3'd4,
        S_GAMEOVER = 3'd5
    } state_t;

    localparam logic [7:0]  KEY_ENTER   = 8'h28;
    localparam logic [7:0]  KEY_LAUNCH  = 8'h16;
    localparam logic [11:0] TURN_INIT   = 12'(TURN_FRAMES);
    localparam logic [11:0] LAUNCH_LAST = 12'(LAUNCH_HOLD - 1);
    localparam logic [11:0] FLIGHT_LAST = 12'(FLIGHT_TIMEOUT - 1);
    localparam logic [11:0] SETTLE_LAST = 12'(SETTLE_FRAMES - 1);

    state_t      state_q, state_d;
    logic [11:0] phase_q, phase_d;
    logic [11:0] time_q, time_d;
    logic        ap_q, ap_d;
    logic [1:0]  win_q, win_d;
    logic        go_q, go_d;
    logic [7:0]  k0_q, k0_d;
    logic [7:0]  k1_q, k1_d;
    logic        exp0_q, exp0_d;
    logic        exp1_q, exp1_d;
    logic        boom;
    logic [7:0]  key_act;

    // Next-state, turn bookkeeping and the key the active player sees next frame
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        ap_d    = ap_q;
        win_d   = win_q;
        key_act = 8'h00;
        exp0_d  = bus.exploded0;
        exp1_d  = bus.exploded1;
        // Only the active player's bomb can end a shot, and only on its rising edge
        boom    = ap_q ? (bus.exploded1 & ~exp1_q) : (bus.exploded0 & ~exp0_q);

        case (state_q)
            S_IDLE: begin
                if (bus.keycode == KEY_ENTER) begin
                    state_d = S_AIM;
                    ap_d    = 1'b0;
                    time_d  = TURN_INIT;
                end
            end
            S_AIM: begin
                // A launch on the final frame still beats the forfeit
                if (bus.keycode == KEY_LAUNCH) begin
                    state_d = S_LAUNCH;
                    key_act = KEY_LAUNCH;
                end else if (time_q == 12'd0) begin
                    state_d = S_SETTLE;
                end else begin
                    time_d  = time_q - 12'd1;
                    key_act = bus.keycode;
                end
            end
            S_LAUNCH: begin
                // Hold the launch key long enough for the player's aim counter to fire
                if (boom) begin
                    state_d = S_SETTLE;
                end else if (phase_q == LAUNCH_LAST) begin
                    state_d = S_FLIGHT;
                end else begin
                    key_act = KEY_LAUNCH;
                end
            end
            S_FLIGHT: begin
                if (boom || (phase_q == FLIGHT_LAST)) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (phase_q == SETTLE_LAST) begin
                    case ({bus.alive0, bus.alive1})
                        2'b11: begin
                            state_d = S_AIM;
                            ap_d    = ~ap_q;
                            time_d  = TURN_INIT;
                        end
                        2'b01: begin
                            state_d = S_GAMEOVER;
                            win_d   = 2'b10;
                        end
                        2'b10: begin
                            state_d = S_GAMEOVER;
                            win_d   = 2'b01;
                        end
                        default: begin
                            state_d = S_GAMEOVER;
                            win_d   = 2'b11;
                        end
                    endcase
                end
            end
            S_GAMEOVER: begin
                if (bus.keycode == KEY_ENTER) begin
                    state_d = S_IDLE;
                    win_d   = 2'b00;
                    ap_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        phase_d = (state_d != state_q) ? 12'd0 : phase_q + 12'd1;
        go_d    = (state_d == S_GAMEOVER);
        k0_d    = ap_q ? 8'h00 : key_act;
        k1_d    = ap_q ? key_act : 8'h00;
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge frame_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= 12'd0;
            time_q  <= 12'd0;
            ap_q    <= 1'b0;
            win_q   <= 2'b00;
            go_q    <= 1'b0;
            k0_q    <= 8'h00;
            k1_q    <= 8'h00;
            exp0_q  <= 1'b0;
            exp1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            time_q  <= time_d;
            ap_q    <= ap_d;
            win_q   <= win_d;
            go_q    <= go_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            exp0_q  <= exp0_d;
            exp1_q  <= exp1_d;
        end
    end

    assign bus.state         = state_q;
    assign bus.time_left     = time_q;
    assign bus.active_player = ap_q;
    assign bus.winner        = win_q;
    assign bus.game_over     = go_q;
    assign bus.key0          = k0_q;
    assign bus.key1          = k1_q;
endmodule

// File: tb/tb_turn_scheduler.sv
// tb/tb_turn_scheduler.sv - self-checking bench for turn_scheduler against a frame-level game model
module tb_turn_scheduler;
    localparam int TF = 1800;
    localparam int LH = 20;
    localparam int FT = 600;
    localparam int SF = 60;

    localparam int ST_IDLE     = 0;
    localparam int ST_AIM      = 1;
    localparam int ST_LAUNCH   = 2;
    localparam int ST_FLIGHT   = 3;
    localparam int ST_SETTLE   = 4;
    localparam int ST_GAMEOVER = 5;

    logic frame_clk = 1'b0;
    logic reset;

    turn_scheduler_if bus ();

    turn_scheduler dut (
        .frame_clk (frame_clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Game model: what each output should read during the next frame
    int m_state, m_frames, m_time, m_ap, m_win, m_go, m_k0, m_k1;
    bit m_prev0, m_prev1;

    int cnt, cnt_bad, d;
    logic [7:0] k;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state = ST_IDLE; m_frames = 0; m_time = 0; m_ap = 0;
        m_win = 0; m_go = 0; m_k0 = 0; m_k1 = 0; m_prev0 = 0; m_prev1 = 0;
    endtask

    task automatic model_step();
        int ns, nt, nap, nw, shown;
        bit boom;
        ns = m_state; nt = m_time; nap = m_ap; nw = m_win; shown = 0;
        boom = (m_ap == 1) ? (bus.exploded1 && !m_prev1) : (bus.exploded0 && !m_prev0);
        if (m_state == ST_IDLE) begin
            if (bus.keycode == 8'h28) begin ns = ST_AIM; nap = 0; nt = TF; end
        end else if (m_state == ST_AIM) begin
            if (bus.keycode == 8'h16) ns = ST_LAUNCH;
            else if (m_time == 0) ns = ST_SETTLE;
            else nt = m_time - 1;
        end else if (m_state == ST_LAUNCH) begin
            if (boom) ns = ST_SETTLE;
            else if (m_frames + 1 == LH) ns = ST_FLIGHT;
        end else if (m_state == ST_FLIGHT) begin
            if (boom || m_frames + 1 == FT) ns = ST_SETTLE;
        end else if (m_state == ST_SETTLE) begin
            if (m_frames + 1 == SF) begin
                if (bus.alive0 && bus.alive1) begin
                    ns = ST_AIM; nap = 1 - m_ap; nt = TF;
                end else begin
                    ns = ST_GAMEOVER;
                    nw = (bus.alive0 ? 0 : 2) + (bus.alive1 ? 0 : 1);
                end
            end
        end else if (m_state == ST_GAMEOVER) begin
            if (bus.keycode == 8'h28) begin ns = ST_IDLE; nw = 0; nap = 0; end
        end
        if (ns == ST_LAUNCH) shown = 8'h16;
        else if (m_state == ST_AIM && ns == ST_AIM) shown = int'(bus.keycode);
        m_k0 = (m_ap == 0) ? shown : 0;
        m_k1 = (m_ap == 1) ? shown : 0;
        m_frames = (ns == m_state) ? m_frames + 1 : 0;
        m_state = ns; m_time = nt; m_ap = nap; m_win = nw;
        m_go = (ns == ST_GAMEOVER) ? 1 : 0;
        m_prev0 = bus.exploded0; m_prev1 = bus.exploded1;
    endtask

    task automatic check_all();
        check("state", bus.state, m_state);
        check("active_player", bus.active_player, m_ap);
        check("time_left", bus.time_left, m_time);
        check("winner", bus.winner, m_win);
        check("game_over", bus.game_over, m_go);
        check("key0", bus.key0, m_k0);
        check("key1", bus.key1, m_k1);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        if (reset) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    task automatic run_until(input int st, input int budget);
        int n;
        n = 0;
        while (int'(bus.state) != st && n < budget) begin
            tick();
            n++;
        end
        check("reach_state", bus.state, st);
    endtask

    function automatic logic [7:0] rand_key();
        logic [7:0] r;
        r = 8'(32'h04 + $urandom_range(0, 25));
        if (r == 8'h16) r = 8'h17;
        return r;
    endfunction

    task automatic press(input logic [7:0] kc);
        bus.keycode = kc;
        tick();
        bus.keycode = 8'h00;
    endtask

    initial begin
        reset = 1'b1;
        bus.keycode = 8'h00;
        bus.exploded0 = 1'b0; bus.exploded1 = 1'b0;
        bus.alive0 = 1'b1; bus.alive1 = 1'b1;
        model_reset();
        repeat (2) @(posedge frame_clk);
        #1;
        check_all();
        reset = 1'b0;
        tick();

        // Enter starts player 0's aim; keys pass through one frame late
        press(8'h28);
        check("enter_state", bus.state, ST_AIM);
        check("enter_time", bus.time_left, TF);
        for (int i = 0; i < 10; i++) begin
            k = rand_key();
            bus.keycode = k;
            tick();
            check("key0_lag", bus.key0, k);
            check("key1_gated", bus.key1, 0);
            check("time_dec", bus.time_left, TF - i - 1);
        end

        // Launch: key0 forced for the hold, then flight, explosion, settle, handover
        press(8'h16);
        cnt = 0;
        for (int i = 0; i < 100 && int'(bus.state) != ST_FLIGHT; i++) begin
            if (int'(bus.state) == ST_LAUNCH && bus.key0 == 8'h16) cnt++;
            tick();
        end
        check("launch_hold", cnt, LH);
        d = $urandom_range(3, 40);
        repeat (d) tick();
        bus.exploded0 = 1'b1;
        tick();
        bus.exploded0 = 1'b0;
        check("explode_settle", bus.state, ST_SETTLE);
        cnt = 0;
        for (int i = 0; i < 200 && int'(bus.state) == ST_SETTLE; i++) begin
            cnt++;
            tick();
        end
        check("settle_len", cnt, SF);
        check("handover_state", bus.state, ST_AIM);
        check("handover_player", bus.active_player, 1);
        check("handover_time", bus.time_left, TF);

        // Player 1 never launches: forfeit straight into settle
        cnt = 1; cnt_bad = 0;
        for (int i = 0; i < 2000 && int'(bus.state) == ST_AIM; i++) begin
            bus.keycode = rand_key();
            tick();
            if (int'(bus.state) == ST_AIM) cnt++;
            if (int'(bus.state) == ST_LAUNCH || bus.key1 == 8'h16) cnt_bad++;
        end
        bus.keycode = 8'h00;
        check("forfeit_aim_frames", cnt, TF + 1);
        check("forfeit_no_launch", cnt_bad, 0);
        check("forfeit_settle", bus.state, ST_SETTLE);
        run_until(ST_AIM, 100);
        check("forfeit_handover", bus.active_player, 0);

        // Flight timeout; the inactive player's bomb is ignored; player 1 dies
        press(8'h16);
        run_until(ST_FLIGHT, 50);
        cnt = 0;
        for (int i = 0; i < 1000 && int'(bus.state) == ST_FLIGHT; i++) begin
            cnt++;
            bus.exploded1 = (i == 7 || i == 300) ? 1'b1 : 1'b0;
            if (i == 200) bus.alive1 = 1'b0;
            tick();
        end
        bus.exploded1 = 1'b0;
        check("flight_timeout", cnt, FT);
        run_until(ST_GAMEOVER, 100);
        check("win_p0", bus.winner, 2'b01);
        check("gameover_flag", bus.game_over, 1);
        for (int i = 0; i < 5; i++) begin
            bus.keycode = rand_key();
            tick();
        end
        press(8'h28);
        check("restart_idle", bus.state, ST_IDLE);
        check("restart_winner", bus.winner, 0);

        // Explosion during launch goes straight to settle; both die -> draw
        bus.alive1 = 1'b1;
        press(8'h28);
        press(8'h16);
        d = $urandom_range(2, 15);
        repeat (d) tick();
        bus.exploded0 = 1'b1;
        tick();
        bus.exploded0 = 1'b0;
        check("launch_boom", bus.state, ST_SETTLE);
        bus.alive0 = 1'b0; bus.alive1 = 1'b0;
        run_until(ST_GAMEOVER, 100);
        check("win_draw", bus.winner, 2'b11);
        press(8'h28);
        check("draw_idle", bus.state, ST_IDLE);

        // Launch on the last aim frame wins over forfeit; player 0 dies
        bus.alive0 = 1'b1; bus.alive1 = 1'b1;
        press(8'h28);
        for (int i = 0; i < 2000 && bus.time_left != 12'd0; i++) tick();
        check("time_floor", bus.time_left, 0);
        press(8'h16);
        check("launch_at_zero", bus.state, ST_LAUNCH);
        run_until(ST_FLIGHT, 50);
        repeat (5) tick();
        bus.exploded0 = 1'b1;
        tick();
        bus.exploded0 = 1'b0;
        bus.alive0 = 1'b0;
        run_until(ST_GAMEOVER, 100);
        check("win_p1", bus.winner, 2'b10);
        press(8'h28);

        // Reset mid-flight with the launch key held takes effect without a clock edge
        bus.alive0 = 1'b1;
        press(8'h28);
        bus.keycode = 8'h16;
        tick();
        run_until(ST_FLIGHT, 50);
        repeat (4) tick();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_state", bus.state, 0);
        check("async_time", bus.time_left, 0);
        check("async_keys", {bus.key0, bus.key1}, 0);
        check_all();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("held_idle", bus.state, ST_IDLE);
        press(8'h28);
        check("resume_aim", bus.state, ST_AIM);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
